// File: rtl/timer_sequencer_if.sv
// Register-write and start/end handshake between the profile sequencer and its timer.
interface timer_sequencer_if #(
    parameter int DW = 16
);
    logic          tmr_we;
    logic [1:0]    tmr_addr;
    logic [DW-1:0] tmr_wdata;
    logic          tmr_start;
    logic          tmr_end;

    modport master (
        output tmr_we,
        output tmr_addr,
        output tmr_wdata,
        output tmr_start,
        input  tmr_end
    );

    modport slave (
        input  tmr_we,
        input  tmr_addr,
        input  tmr_wdata,
        input  tmr_start,
        output tmr_end
    );
endinterface

// File: rtl/timer_sequencer.sv
// Profile sequencer: walks a host-written table of timer profiles, loading each into the
// timer, starting it and waiting for its end, with optional looping and abort.
module timer_sequencer #(
    parameter int DW    = 16,
    parameter int NPROF = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_we,
    input  logic [3:0]        i_cfg_addr,
    input  logic [DW-1:0]     i_cfg_wdata,
    input  logic              i_go,
    input  logic              i_loop,
    input  logic              i_abort,
    timer_sequencer_if.master tmr,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_cur_prof
);
    localparam int IW = 2;
    localparam int SW = IW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD0 = 3'd1,
        ST_LOAD1 = 3'd2,
        ST_LOAD2 = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_NEXT  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Returns {found, index} of the lowest enabled entry whose index is >= start.
    function automatic logic [SW-1:0] find_enabled(input logic [NPROF-1:0] en,
                                                   input logic [SW-1:0]    start);
        logic [SW-1:0] res;
        res = {SW{1'b0}};
        for (int i = NPROF - 1; i >= 0; i--) begin
            res = (en[i] && (SW'(i) >= start)) ? {1'b1, IW'(i)} : res;
        end
        return res;
    endfunction

    logic [DW-1:0]    period_r [NPROF];
    logic [DW-1:0]    duty_r   [NPROF];
    logic [DW-1:0]    rpt_r    [NPROF];
    logic [NPROF-1:0] en_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IW-1:0]    cur_r;
    logic [IW-1:0]    cur_nxt_s;
    logic             loop_r;
    logic             loop_nxt_s;
    logic             end_prev_r;

    logic             abort_s;
    logic             end_rise_s;
    logic [SW-1:0]    first_s;
    logic [SW-1:0]    above_s;

    logic             we_s;
    logic [1:0]       addr_s;
    logic [DW-1:0]    wdata_s;
    logic             start_s;
    logic             busy_s;
    logic             done_s;

    assign abort_s    = i_abort && (state_r != ST_IDLE);
    assign end_rise_s = tmr.tmr_end && !end_prev_r;
    assign first_s    = find_enabled(en_r, 3'd0);
    assign above_s    = find_enabled(en_r, {1'b0, cur_r} + 3'd1);

    // Host profile table; writes land in any state and only affect later loads.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NPROF; i++) begin
                period_r[i] <= {DW{1'b0}};
                duty_r[i]   <= {DW{1'b0}};
                rpt_r[i]    <= {DW{1'b0}};
            end
            en_r <= {NPROF{1'b0}};
        end else if (i_cfg_we) begin
            case (i_cfg_addr[1:0])
                2'd0:    period_r[i_cfg_addr[3:2]] <= i_cfg_wdata;
                2'd1:    duty_r[i_cfg_addr[3:2]]   <= i_cfg_wdata;
                2'd2:    rpt_r[i_cfg_addr[3:2]]    <= i_cfg_wdata;
                2'd3:    en_r[i_cfg_addr[3:2]]     <= i_cfg_wdata[0];
                default: en_r                      <= en_r;
            endcase
        end
    end

    // Sequencer state, current profile, latched loop mode and timer-end history.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            cur_r      <= 2'd0;
            loop_r     <= 1'b0;
            end_prev_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_r      <= cur_nxt_s;
            loop_r     <= loop_nxt_s;
            end_prev_r <= tmr.tmr_end;
        end
    end

    // Next-state selection; abort overrides every non-idle transition.
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        loop_nxt_s  = loop_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_go && !i_abort) begin
                        loop_nxt_s = i_loop;
                        if (first_s[IW]) begin
                            state_nxt_s = ST_LOAD0;
                            cur_nxt_s   = first_s[IW-1:0];
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD0: state_nxt_s = ST_LOAD1;
                ST_LOAD1: state_nxt_s = ST_LOAD2;
                ST_LOAD2: state_nxt_s = ST_START;
                ST_START: state_nxt_s = ST_WAIT;
                ST_WAIT:  state_nxt_s = end_rise_s ? ST_NEXT : ST_WAIT;
                ST_NEXT: begin
                    if (above_s[IW]) begin
                        state_nxt_s = ST_LOAD0;
                        cur_nxt_s   = above_s[IW-1:0];
                    end else if (loop_r && first_s[IW]) begin
                        state_nxt_s = ST_LOAD0;
                        cur_nxt_s   = first_s[IW-1:0];
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode of the current state, registered one cycle later below.
    always_comb begin
        we_s    = 1'b0;
        addr_s  = 2'd0;
        wdata_s = {DW{1'b0}};
        start_s = 1'b0;
        busy_s  = (state_r != ST_IDLE);
        done_s  = 1'b0;
        case (state_r)
            ST_LOAD0: begin
                we_s    = 1'b1;
                addr_s  = 2'd0;
                wdata_s = period_r[cur_r];
            end
            ST_LOAD1: begin
                we_s    = 1'b1;
                addr_s  = 2'd1;
                wdata_s = duty_r[cur_r];
            end
            ST_LOAD2: begin
                we_s    = 1'b1;
                addr_s  = 2'd2;
                wdata_s = rpt_r[cur_r];
            end
            ST_START: start_s = 1'b1;
            ST_DONE:  done_s  = 1'b1;
            default:  done_s  = 1'b0;
        endcase
    end

    // Registered outputs; an abort silences the timer port and done in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || abort_s) begin
            tmr.tmr_we    <= 1'b0;
            tmr.tmr_addr  <= 2'd0;
            tmr.tmr_wdata <= {DW{1'b0}};
            tmr.tmr_start <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_cur_prof    <= !i_rst_n ? 2'd0 : o_cur_prof;
        end else begin
            tmr.tmr_we    <= we_s;
            tmr.tmr_addr  <= addr_s;
            tmr.tmr_wdata <= wdata_s;
            tmr.tmr_start <= start_s;
            o_busy        <= busy_s;
            o_done        <= done_s;
            o_cur_prof    <= cur_r;
        end
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// Directed plus randomized bench for timer_sequencer, checked against a table/visit-order model.
module tb_timer_sequencer;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [3:0]  i_cfg_addr = 4'd0;
    logic [15:0] i_cfg_wdata = 16'd0;
    logic        i_go = 1'b0;
    logic        i_loop = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_cur_prof;

    int checks = 0;
    int errors = 0;
    int n_we = 0;
    logic [15:0] m_tab [4][3];
    logic [3:0]  m_en;

    always #5 i_clk = ~i_clk;

    timer_sequencer_if #(.DW(16)) tif ();

    timer_sequencer #(.DW(16), .NPROF(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_wdata (i_cfg_wdata),
        .i_go        (i_go),
        .i_loop      (i_loop),
        .i_abort     (i_abort),
        .tmr         (tif.master),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cur_prof  (o_cur_prof)
    );

    always @(negedge i_clk) if (tif.tmr_we === 1'b1) n_we++;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model: first enabled index strictly above cur (cur = -1 means from the start).
    function automatic int first_above(input int cur);
        for (int i = cur + 1; i < 4; i++) if (m_en[i]) return i;
        return -1;
    endfunction

    function automatic int model_next(input int cur, input bit lp);
        int n;
        n = first_above(cur);
        if (n < 0 && lp) n = first_above(-1);
        return n;
    endfunction

    task automatic cfg_write(input int idx, input int field, input logic [15:0] val);
        i_cfg_we = 1'b1;
        i_cfg_addr = 4'(idx * 4 + field);
        i_cfg_wdata = val;
        tick();
        i_cfg_we = 1'b0;
        if (field == 3) m_en[idx] = val[0];
        else m_tab[idx][field] = val;
    endtask

    task automatic set_profile(input int idx, input logic [15:0] per, input logic [15:0] dty,
                               input logic [15:0] rpt, input logic en);
        cfg_write(idx, 0, per);
        cfg_write(idx, 1, dty);
        cfg_write(idx, 2, rpt);
        cfg_write(idx, 3, {15'd0, en});
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) for (int f = 0; f < 3; f++) m_tab[i][f] = 16'd0;
        m_en = 4'd0;
    endtask

    task automatic expect_load(input int p);
        for (int f = 0; f < 3; f++) begin
            tick();
            check("load_we", 32'(tif.tmr_we), 1);
            check("load_addr", 32'(tif.tmr_addr), f);
            check("load_data", 32'(tif.tmr_wdata), 32'(m_tab[p][f]));
            check("cur_prof", 32'(o_cur_prof), p);
            check("load_busy", 32'(o_busy), 1);
        end
        tick();
        check("start_pulse", 32'(tif.tmr_start), 1);
        check("start_no_we", 32'(tif.tmr_we), 0);
    endtask

    task automatic expect_done();
        tick();
        check("done_pulse", 32'(o_done), 1);
        check("done_busy", 32'(o_busy), 1);
        check("done_no_we", 32'(tif.tmr_we), 0);
        tick();
        check("done_clear", 32'(o_done), 0);
        check("busy_fall", 32'(o_busy), 0);
    endtask

    // Timer end pulse followed by the two-cycle turnaround with no timer activity.
    task automatic end_pulse();
        tif.tmr_end = 1'b1;
        tick();
        tif.tmr_end = 1'b0;
        check("turn_we0", 32'(tif.tmr_we), 0);
        tick();
        check("turn_we1", 32'(tif.tmr_we), 0);
        check("turn_done", 32'(o_done), 0);
    endtask

    task automatic run_seq(input bit lp, input int maxv, input bit rewrite);
        int p;
        int nxt;
        int visits;
        int w;
        p = first_above(-1);
        i_go = 1'b1;
        i_loop = lp;
        tick();
        i_go = 1'b0;
        i_loop = 1'b0;
        check("go_latency", 32'(o_busy), 0);
        if (p < 0) begin
            expect_done();
            return;
        end
        visits = 0;
        forever begin
            expect_load(p);
            visits++;
            if (rewrite && visits == 1) cfg_write(p, 0, 16'd40);
            w = $urandom_range(0, 4);
            repeat (w) begin
                tick();
                check("wait_we", 32'(tif.tmr_we), 0);
                check("wait_busy", 32'(o_busy), 1);
            end
            if (lp && visits >= maxv) begin
                i_abort = 1'b1;
                tick();
                i_abort = 1'b0;
                check("abort_busy", 32'(o_busy), 0);
                check("abort_we", 32'(tif.tmr_we), 0);
                check("abort_start", 32'(tif.tmr_start), 0);
                repeat (3) begin
                    tick();
                    check("abort_no_done", 32'(o_done), 0);
                    check("abort_idle", 32'(o_busy), 0);
                end
                return;
            end
            end_pulse();
            nxt = model_next(p, lp);
            if (nxt < 0) begin
                expect_done();
                return;
            end
            p = nxt;
        end
    endtask

    initial begin
        int n0;
        tif.tmr_end = 1'b0;
        clear_model();
        repeat (3) tick();
        check("rst_we", 32'(tif.tmr_we), 0);
        check("rst_start", 32'(tif.tmr_start), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_cur", 32'(o_cur_prof), 0);
        check("rst_wdata", 32'(tif.tmr_wdata), 0);
        i_rst_n = 1'b1;
        tick();

        // Single profile, no loop.
        set_profile(0, 16'd20, 16'd10, 16'd2, 1'b1);
        run_seq(1'b0, 1, 1'b0);

        // Profiles 0 and 2, looped, aborted in WAIT.
        set_profile(2, 16'd8, 16'd4, 16'd1, 1'b1);
        run_seq(1'b1, 5, 1'b0);

        // Period rewrite of the running profile during WAIT.
        cfg_write(2, 3, 16'd0);
        run_seq(1'b1, 2, 1'b1);

        // Timer end already high on WAIT entry must not advance.
        cfg_write(0, 0, 16'd20);
        tif.tmr_end = 1'b1;
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        expect_load(0);
        repeat (4) begin
            tick();
            check("held_no_adv", 32'(tif.tmr_we), 0);
            check("held_busy", 32'(o_busy), 1);
        end
        tif.tmr_end = 1'b0;
        tick();
        check("held_drop", 32'(o_done), 0);
        end_pulse();
        expect_done();

        // Disabling every entry during a looped run ends via DONE.
        cfg_write(2, 3, 16'd1);
        i_go = 1'b1;
        i_loop = 1'b1;
        tick();
        i_go = 1'b0;
        i_loop = 1'b0;
        expect_load(0);
        cfg_write(0, 3, 16'd0);
        cfg_write(2, 3, 16'd0);
        end_pulse();
        expect_done();

        // Empty table: immediate done, no timer writes.
        n0 = n_we;
        run_seq(1'b0, 1, 1'b0);
        tick();
        check("empty_no_we", 32'(n_we), 32'(n0));

        // go and abort together in IDLE: abort wins.
        cfg_write(1, 3, 16'd1);
        i_go = 1'b1;
        i_abort = 1'b1;
        tick();
        i_go = 1'b0;
        i_abort = 1'b0;
        repeat (2) begin
            tick();
            check("go_abort_idle", 32'(o_busy), 0);
            check("go_abort_we", 32'(tif.tmr_we), 0);
        end

        // Randomized tables and modes.
        repeat (6) begin
            for (int i = 0; i < 4; i++)
                set_profile(i, 16'($urandom), 16'($urandom), 16'($urandom),
                            1'($urandom_range(0, 1)));
            run_seq(1'($urandom_range(0, 1)), $urandom_range(2, 6), 1'b0);
        end

        // Reset during LOAD1 clears outputs and table.
        set_profile(3, 16'd7, 16'd3, 16'd5, 1'b1);
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        tick();
        check("pre_rst_we", 32'(tif.tmr_we), 1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        clear_model();
        check("mid_rst_we", 32'(tif.tmr_we), 0);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_cur", 32'(o_cur_prof), 0);
        check("mid_rst_wdata", 32'(tif.tmr_wdata), 0);
        n0 = n_we;
        run_seq(1'b0, 1, 1'b0);
        tick();
        check("post_rst_no_we", 32'(n_we), 32'(n0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
